rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one mux/demux-steered resource among N requesters.

---
 rtl/rr_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for a shared mux/demux-steered resource: registered one-hot
// grant and binary select, break-before-make hand-over, optional hold-limit preemption.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             preempt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LIM_V = HOLD_W'(HOLD_LIM);
    localparam logic [N-1:0]      ONE_N      = N'(1);

    state_t            state_r, state_nxt_s;
    logic [SEL_W-1:0]  ptr_r, ptr_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic [N-1:0]      grant_r, grant_nxt_s;
    logic [SEL_W-1:0]  sel_r, sel_nxt_s;
    logic              preempt_r, preempt_nxt_s;
    logic              busy_r;

    logic [SEL_W-1:0]  winner_s;
    logic [SEL_W-1:0]  idx_s;
    logic              found_s;
    logic [N-1:0]      owner_mask_s;
    logic              owner_req_s;
    logic              others_s;
    logic              limit_hit_s;

    // Rotating priority scan: first requester after the last owner wins
    always_comb begin
        winner_s = '0;
        idx_s    = '0;
        found_s  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s = SEL_W'((int'(ptr_r) + k) % N);
            if (!found_s && req[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Owner status and hold-limit detection
    always_comb begin
        owner_mask_s = ONE_N << ptr_r;
        owner_req_s  = |(req & owner_mask_s);
        others_s     = |(req & ~owner_mask_s);
        limit_hit_s  = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LIM_V);
    end

    // Next-state and next-output logic; grant always drops for one IDLE cycle between owners
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        grant_nxt_s    = '0;
        sel_nxt_s      = sel_r;
        preempt_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_nxt_s    = ONE_N << winner_s;
                    sel_nxt_s      = winner_s;
                    ptr_nxt_s      = winner_s;
                    hold_cnt_nxt_s = '0;
                    state_nxt_s    = GRANT;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    state_nxt_s = IDLE;
                end else if (limit_hit_s && others_s) begin
                    // ptr stays on the evicted owner so it ranks last next time
                    preempt_nxt_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    grant_nxt_s = grant_r;
                    if (hold_cnt_r != HOLD_LIM_V) begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= SEL_W'(N - 1);
            hold_cnt_r <= '0;
            grant_r    <= '0;
            sel_r      <= '0;
            preempt_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            grant_r    <= grant_nxt_s;
            sel_r      <= sel_nxt_s;
            preempt_r  <= preempt_nxt_s;
            busy_r     <= |grant_nxt_s;
        end
    end

    assign grant   = grant_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign preempt = preempt_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (N=4, MAX_HOLD=4) with hand-computed expectations.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    int n_checks;
    int n_fail;

    rr_arbiter #(.N(4), .SEL_W(2), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic p);
        check({tag, ".grant"},   {28'd0, grant},   {28'd0, g});
        check({tag, ".sel"},     {30'd0, sel},     {30'd0, s});
        check({tag, ".busy"},    {31'd0, busy},    {31'd0, b});
        check({tag, ".preempt"}, {31'd0, preempt}, {31'd0, p});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 4'b1111;
        #3;
        expect_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Rotation with every requester active: 4 grant cycles, then preempt/idle cycle
        rst_n = 1'b1;
        step();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 4; c++) begin
                expect_out("rot.grant", 4'b0001 << w, 2'(w), 1'b1, 1'b0);
                step();
            end
            expect_out("rot.idle", 4'b0000, 2'(w), 1'b0, 1'b1);
            step();
        end
        for (int c = 0; c < 3; c++) begin
            expect_out("rot.wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
            step();
        end
        expect_out("rot.wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
        // Drop on the very cycle the limit is hit: plain release
        req = 4'b0000;
        step();
        expect_out("limit.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("idle.empty", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request, one-edge latency, release
        req = 4'b0001;
        step();
        expect_out("single", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        expect_out("single.rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fairness: owner 1 re-requests in IDLE but ranks after requester 2
        req = 4'b0010;
        step();
        expect_out("fair.own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0100;
        step();
        expect_out("fair.rel", 4'b0000, 2'd1, 1'b0, 1'b0);
        req = 4'b0110;
        step();
        expect_out("fair.next", 4'b0100, 2'd2, 1'b1, 1'b0);

        // No competitor: hold indefinitely, never preempt
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step();
            expect_out("nocomp", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        // Competitor arrives with counter saturated: immediate preempt, owner goes last
        req = 4'b0101;
        step();
        expect_out("late.preempt", 4'b0000, 2'd2, 1'b0, 1'b1);
        step();
        expect_out("late.next", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Reach owner 3, then reset asynchronously mid-grant
        req = 4'b1000;
        step();
        expect_out("to3.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("to3.grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        expect_out("async.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        expect_out("post.rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
